pipe_id_hazard: RTL and testbench
=================================

PIPE_ID_HAZARD -- requirements
Module: pipe_id_hazard

Interface
REQ-001 Parameter NSTAGE, default 3: number of downstream stages tracked (stage 0 = EX ... stage NSTAGE-1 = WB); legal range 2..6.
REQ-002 Parameter DW, default 32: register data width.
REQ-003 Parameter AW, default 5: register address width.
REQ-004 Parameter LOAD_RDY, default 1: first stage index at which load data is forwardable; legal range 0..NSTAGE-1.
REQ-005 Parameter FWD_EN, default 1: 1 = forward and stall only when data not ready; 0 = stall on any pending match (no forwarding).
REQ-006 in_clk  input  1  clock; all state updates on the rising edge.
REQ-007 in_rst  input  1  reset; asynchronous, active-high.
REQ-008 in_rs_addr, in_rt_addr  input  AW each  ID source register addresses.
REQ-009 in_rs_rena, in_rt_rena  input  1 each  source read enables.
REQ-010 in_issue_valid  input  1  ID holds a valid instruction.
REQ-011 in_rd_waddr  input  AW; in_rd_wena  input  1; in_rd_is_load  input  1  ID destination info.
REQ-012 in_flush  input  1  squash the ID instruction this cycle (taken branch/jump).
REQ-013 in_rf_rs_data, in_rf_rt_data  input  DW each  register-file read data.
REQ-014 in_stage_data  input  NSTAGE*DW  result of stage k on bits [k*DW +: DW].
REQ-015 out_rs_data, out_rt_data  output  DW each  operand data after forwarding.
REQ-016 out_stall  output  1  hold IF/ID; inject a bubble into stage 0.
REQ-017 out_stall_cnt, out_fwd_cnt  output  32 each  saturating event counters.

Function
REQ-018 Scoreboard: NSTAGE entries {valid, waddr, is_load}; entry k describes the instruction currently in stage k.
REQ-019 Every cycle, entry k shifts to entry k+1; entry NSTAGE-1 is discarded; downstream stages never stall.
REQ-020 Entry 0 loads {1, in_rd_waddr, in_rd_is_load} when in_issue_valid & in_rd_wena & in_rd_waddr!=0 & !out_stall & !in_flush; otherwise it loads a bubble (valid=0).
REQ-021 Match for source s: s_rena & s_addr!=0 & entry.valid & entry.waddr==s_addr; register 0 never matches.
REQ-022 Selection: the youngest matching entry (lowest k) wins; older matches are ignored.
REQ-023 Ready: a non-load entry is ready in any stage; a load entry is ready only when k>=LOAD_RDY.
REQ-024 FWD_EN=1: on a ready match, out data = in_stage_data slice k; with no match, out data = register-file data.
REQ-025 FWD_EN=1: out_stall=1 when any selected match is not ready.
REQ-026 FWD_EN=0: out_stall=1 on any match; out data is always register-file data.
REQ-027 The register file shall be written by stage NSTAGE-1 at its clock edge; an entry that has left the scoreboard is read from the register file.
REQ-028 out_stall is gated by in_issue_valid and forced 0 when in_flush=1; flush wins over stall.
REQ-029 out_stall, out_rs_data and out_rt_data are combinational: zero-cycle latency from inputs and the scoreboard.
REQ-030 out_stall_cnt increments on each cycle with out_stall=1 and saturates at 0xFFFFFFFF.
REQ-031 out_fwd_cnt increments by 1 per cycle in which at least one operand is forwarded with out_stall=0, and saturates at 0xFFFFFFFF.

Reset
REQ-032 While in_rst=1, all scoreboard entries are invalid and both counters read 0; hence out_stall=0 and out data = register-file data.
REQ-033 Reset asserted mid-operation drops all pending entries immediately, without waiting for a clock edge.

Structure
REQ-034 A shared package holds the scoreboard entry typedef and the constants REG_ZERO and CNT_MAX.
REQ-035 One sub-module, sat_counter (32-bit, increment enable, asynchronous clear), is instantiated twice.

Verification
REQ-036 Scenario: add r3 in EX, ID reads r3 -> no stall; out_rs_data = stage-0 data 0x0000_0011; fwd_cnt increments by 1.
REQ-037 Scenario: lw r4 in EX with LOAD_RDY=1, ID reads r4 -> exactly one stall cycle; next cycle out = stage-1 data 0xDEAD_BEEF.
REQ-038 Scenario: r5 written in EX and in MEM with different values (0x1 in EX, 0x2 in MEM) -> out selects the EX value 0x1.
REQ-039 Scenario: ID reads r0 while r0 is "pending" via in_rd_waddr=0 -> no stall; out = register-file data.
REQ-040 Scenario: stall condition together with in_flush=1 -> out_stall=0 and a bubble enters stage 0; FWD_EN=0 with a dependency on EX -> NSTAGE stall cycles.
REQ-041 Scenario: force the stall counter to 0xFFFFFFFE, then run 3 stall cycles -> counter holds 0xFFFFFFFF; assert reset mid-stall -> out_stall=0 immediately and counters read 0.

Source files
------------

// File: rtl/pipe_id_hazard_pkg.sv
// Shared types and constants for the ID-stage hazard unit: scoreboard entry
// layout, the hard-wired zero register and the counter saturation value.
package pipe_id_hazard_pkg;

    // Scoreboard addresses are stored zero-extended to a fixed width so the
    // entry type does not depend on the AW parameter of any one instance.
    localparam int SB_AW = 8;

    localparam logic [SB_AW-1:0] REG_ZERO = '0;
    localparam logic [31:0]      CNT_MAX  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] waddr;
        logic             is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, waddr: REG_ZERO, is_load: 1'b0};

    function automatic logic entry_match(input sb_entry_t e, input logic rena,
                                         input logic [SB_AW-1:0] addr);
        return rena && (addr != REG_ZERO) && e.valid && (e.waddr == addr);
    endfunction

endpackage

// File: rtl/pipe_id_hazard_sat_counter.sv
// 32-bit event counter that sticks at its maximum value; cleared
// asynchronously by rst.
module sat_counter
    import pipe_id_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_id_hazard.sv
// ID-stage data-hazard unit: tracks in-flight destination registers, forwards
// the youngest ready result to the operands and stalls IF/ID otherwise.
module pipe_id_hazard
    import pipe_id_hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LOAD_RDY = 1,
    parameter int FWD_EN   = 1
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [AW-1:0]      in_rs_addr,
    input  logic [AW-1:0]      in_rt_addr,
    input  logic               in_rs_rena,
    input  logic               in_rt_rena,
    input  logic               in_issue_valid,
    input  logic [AW-1:0]      in_rd_waddr,
    input  logic               in_rd_wena,
    input  logic               in_rd_is_load,
    input  logic               in_flush,
    input  logic [DW-1:0]      in_rf_rs_data,
    input  logic [DW-1:0]      in_rf_rt_data,
    input  logic [NSTAGE*DW-1:0] in_stage_data,
    output logic [DW-1:0]      out_rs_data,
    output logic [DW-1:0]      out_rt_data,
    output logic               out_stall,
    output logic [31:0]        out_stall_cnt,
    output logic [31:0]        out_fwd_cnt
);

    sb_entry_t sb_q [NSTAGE];
    sb_entry_t sb_d [NSTAGE];

    logic [SB_AW-1:0] rs_addr_x;
    logic [SB_AW-1:0] rt_addr_x;
    logic [SB_AW-1:0] rd_addr_x;

    logic          rs_hit, rs_rdy, rt_hit, rt_rdy;
    logic [DW-1:0] rs_fdata, rt_fdata;
    logic          rs_fwd, rt_fwd;
    logic          stall_raw;
    logic          issue_ok;
    logic          fwd_evt;

    assign rs_addr_x = SB_AW'(in_rs_addr);
    assign rt_addr_x = SB_AW'(in_rt_addr);
    assign rd_addr_x = SB_AW'(in_rd_waddr);

    // Walk from the oldest stage to the youngest so the lowest matching k wins.
    always_comb begin
        rs_hit   = 1'b0;
        rs_rdy   = 1'b0;
        rs_fdata = '0;
        rt_hit   = 1'b0;
        rt_rdy   = 1'b0;
        rt_fdata = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (entry_match(sb_q[k], in_rs_rena, rs_addr_x)) begin
                rs_hit   = 1'b1;
                rs_rdy   = !sb_q[k].is_load || (k >= LOAD_RDY);
                rs_fdata = in_stage_data[k*DW +: DW];
            end
            if (entry_match(sb_q[k], in_rt_rena, rt_addr_x)) begin
                rt_hit   = 1'b1;
                rt_rdy   = !sb_q[k].is_load || (k >= LOAD_RDY);
                rt_fdata = in_stage_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        if (FWD_EN != 0) begin
            stall_raw = (rs_hit && !rs_rdy) || (rt_hit && !rt_rdy);
            rs_fwd    = rs_hit && rs_rdy;
            rt_fwd    = rt_hit && rt_rdy;
        end else begin
            stall_raw = rs_hit || rt_hit;
            rs_fwd    = 1'b0;
            rt_fwd    = 1'b0;
        end
    end

    assign out_stall   = in_issue_valid && !in_flush && stall_raw;
    assign out_rs_data = rs_fwd ? rs_fdata : in_rf_rs_data;
    assign out_rt_data = rt_fwd ? rt_fdata : in_rf_rt_data;
    assign fwd_evt     = (rs_fwd || rt_fwd) && !out_stall;

    assign issue_ok = in_issue_valid && in_rd_wena && (rd_addr_x != REG_ZERO)
                      && !out_stall && !in_flush;

    // Downstream stages never stall: the scoreboard is a plain shift register.
    always_comb begin
        sb_d[0] = issue_ok ? '{valid: 1'b1, waddr: rd_addr_x, is_load: in_rd_is_load}
                           : SB_BUBBLE;
        for (int k = 1; k < NSTAGE; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= SB_BUBBLE;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

    sat_counter u_stall_cnt (
        .clk   (in_clk),
        .rst   (in_rst),
        .inc   (out_stall),
        .count (out_stall_cnt)
    );

    sat_counter u_fwd_cnt (
        .clk   (in_clk),
        .rst   (in_rst),
        .inc   (fwd_evt),
        .count (out_fwd_cnt)
    );

endmodule

// File: tb/tb_pipe_id_hazard.sv
// Directed bench for pipe_id_hazard: a forwarding instance and a no-forwarding
// instance share one ID-stage stimulus stream.
module tb_pipe_id_hazard;

    localparam logic [31:0] RF_RS = 32'hAAAA_0001;
    localparam logic [31:0] RF_RT = 32'hBBBB_0002;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, rd_waddr;
    logic        rs_rena, rt_rena, issue_valid, rd_wena, rd_is_load, flush;
    logic [31:0] rf_rs, rf_rt;
    logic [95:0] stage_data;

    logic [31:0] f_rs, f_rt, f_stall_cnt, f_fwd_cnt;
    logic        f_stall;
    logic [31:0] n_rs, n_rt, n_stall_cnt, n_fwd_cnt;
    logic        n_stall;

    int n_total;
    int n_pass;
    int n_cycles;

    pipe_id_hazard #(.NSTAGE(3), .DW(32), .AW(5), .LOAD_RDY(1), .FWD_EN(1)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_rs_addr(rs_addr), .in_rt_addr(rt_addr),
        .in_rs_rena(rs_rena), .in_rt_rena(rt_rena),
        .in_issue_valid(issue_valid),
        .in_rd_waddr(rd_waddr), .in_rd_wena(rd_wena), .in_rd_is_load(rd_is_load),
        .in_flush(flush),
        .in_rf_rs_data(rf_rs), .in_rf_rt_data(rf_rt),
        .in_stage_data(stage_data),
        .out_rs_data(f_rs), .out_rt_data(f_rt), .out_stall(f_stall),
        .out_stall_cnt(f_stall_cnt), .out_fwd_cnt(f_fwd_cnt)
    );

    pipe_id_hazard #(.NSTAGE(3), .DW(32), .AW(5), .LOAD_RDY(1), .FWD_EN(0)) dut_nf (
        .in_clk(clk), .in_rst(rst),
        .in_rs_addr(rs_addr), .in_rt_addr(rt_addr),
        .in_rs_rena(rs_rena), .in_rt_rena(rt_rena),
        .in_issue_valid(issue_valid),
        .in_rd_waddr(rd_waddr), .in_rd_wena(rd_wena), .in_rd_is_load(rd_is_load),
        .in_flush(flush),
        .in_rf_rs_data(rf_rs), .in_rf_rt_data(rf_rt),
        .in_stage_data(stage_data),
        .out_rs_data(n_rs), .out_rt_data(n_rt), .out_stall(n_stall),
        .out_stall_cnt(n_stall_cnt), .out_fwd_cnt(n_fwd_cnt)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Checker and driver tasks.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic iv, input logic [4:0] rd, input logic we,
                            input logic ld, input logic [4:0] rs, input logic rse,
                            input logic [4:0] rt, input logic rte);
        issue_valid = iv;
        rd_waddr    = rd;
        rd_wena     = we;
        rd_is_load  = ld;
        rs_addr     = rs;
        rs_rena     = rse;
        rt_addr     = rt;
        rt_rena     = rte;
        flush       = 1'b0;
        #1;
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic set_stage(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        stage_data = {d2, d1, d0};
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        rf_rs   = RF_RS;
        rf_rt   = RF_RT;
        set_stage(32'h0000_0011, 32'h0000_0022, 32'h0000_0033);
        idle();
        @(negedge clk);
        check("reset_stall", {31'd0, f_stall}, 32'd0);
        check("reset_rs_data", f_rs, RF_RS);
        check("reset_stall_cnt", f_stall_cnt, 32'd0);
        check("reset_fwd_cnt", f_fwd_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU result in EX forwarded to the next instruction.
        drive_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        check("alu_fwd_stall", {31'd0, f_stall}, 32'd0);
        check("alu_fwd_rs", f_rs, 32'h0000_0011);
        check("alu_fwd_rt_rf", f_rt, RF_RT);
        check("alu_fwd_cnt_before", f_fwd_cnt, 32'd0);
        step();
        check("alu_fwd_cnt_after", f_fwd_cnt, 32'd1);
        idle();
        repeat (3) step();

        // Load-use: one bubble, then forward from MEM.
        set_stage(32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0033);
        drive_id(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        check("load_use_stall", {31'd0, f_stall}, 32'd1);
        step();
        check("load_use_release", {31'd0, f_stall}, 32'd0);
        check("load_use_rs", f_rs, 32'hDEAD_BEEF);
        check("load_use_stall_cnt", f_stall_cnt, 32'd1);
        step();
        check("load_use_fwd_cnt", f_fwd_cnt, 32'd2);
        idle();
        repeat (3) step();

        // Same register pending in several stages: youngest wins, then ages out.
        set_stage(32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        drive_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
        check("youngest_rs_ex", f_rs, 32'h0000_0001);
        check("youngest_rt_ex", f_rt, 32'h0000_0001);
        check("youngest_stall", {31'd0, f_stall}, 32'd0);
        step();
        check("youngest_rs_mem", f_rs, 32'h0000_0002);
        step();
        check("youngest_rt_wb", f_rt, 32'h0000_0003);
        step();
        check("aged_out_rs_rf", f_rs, RF_RS);
        check("youngest_fwd_cnt", f_fwd_cnt, 32'd5);
        idle();

        // Register zero never creates a dependency.
        drive_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        check("r0_stall", {31'd0, f_stall}, 32'd0);
        check("r0_rs_rf", f_rs, RF_RS);
        check("r0_rt_rf", f_rt, RF_RT);
        step();
        check("r0_fwd_cnt", f_fwd_cnt, 32'd5);
        idle();

        // Flush overrides a load-use stall and squashes the ID destination.
        drive_id(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
        check("flush_pre_stall", {31'd0, f_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, f_stall}, 32'd0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd6, 1'b1);
        check("flush_bubble_rs_rf", f_rs, RF_RS);
        check("flush_load_rt_mem", f_rt, 32'h0000_0002);
        check("flush_after_stall", {31'd0, f_stall}, 32'd0);
        check("flush_stall_cnt", f_stall_cnt, 32'd1);
        idle();
        repeat (3) step();

        // No-forwarding instance stalls while the producer is anywhere in flight.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        check("nofwd_rs_rf", n_rs, RF_RS);
        n_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!n_stall) break;
            n_cycles++;
            step();
        end
        check("nofwd_stall_cycles", n_cycles, 32'd3);
        check("nofwd_stall_cnt", n_stall_cnt, 32'd3);
        check("nofwd_fwd_cnt", n_fwd_cnt, 32'd0);
        idle();

        // Stall counter saturation, then reset in the middle of a stall.
        drive_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        force dut_nf.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut_nf.u_stall_cnt.cnt_q;
        #1;
        check("sat_preload", n_stall_cnt, 32'hFFFF_FFFE);
        step();
        check("sat_first", n_stall_cnt, 32'hFFFF_FFFF);
        step();
        step();
        check("sat_hold", n_stall_cnt, 32'hFFFF_FFFF);
        drive_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        drive_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        check("midstall_pre", {31'd0, n_stall}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midstall_reset_stall", {31'd0, n_stall}, 32'd0);
        check("midstall_reset_rs_rf", n_rs, RF_RS);
        check("midstall_reset_nf_cnt", n_stall_cnt, 32'd0);
        check("midstall_reset_fwd_cnt", f_fwd_cnt, 32'd0);
        check("midstall_reset_f_rs_rf", f_rs, RF_RS);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
